motion_mode_scheduler: RTL and testbench

- Top-level motion sequencer for the robot. Selects spiral search, turn-around (reverse/rotate) or straight cruise, and drives the enable of each behaviour block.
- Multiplexes the selected block's speed/command onto the shared motor-command bus.
- Sits between the sensor front-end (bump, cliff) and the spiral and turn-around movers. Owns when the turn-around mover is enabled, re-armed and released.

---
 rtl/motion_mode_scheduler_if.sv | 22 ++
 rtl/motion_mode_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_motion_mode_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/motion_mode_scheduler_if.sv
// Mover/motor bus for the motion scheduler: behaviour-block speed/command in,
// enables and the selected speed/command out.
interface motion_mode_scheduler_if;
    logic [2:0] spiral_speed;
    logic [9:0] spiral_command;
    logic [2:0] turn_speed;
    logic [9:0] turn_command;
    logic       spiral_enable;
    logic       turn_enable;
    logic [2:0] output_speed;
    logic [9:0] motion_command;

    modport master (
        input  spiral_speed, spiral_command, turn_speed, turn_command,
        output spiral_enable, turn_enable, output_speed, motion_command
    );

    modport slave (
        output spiral_speed, spiral_command, turn_speed, turn_command,
        input  spiral_enable, turn_enable, output_speed, motion_command
    );
endinterface

// File: rtl/motion_mode_scheduler.sv
// Motion sequencer: spiral / turn-around / cruise selection, bump debounce and motor-bus mux.
// Optional spin watchdog enabled by defining MOTION_SPIN_WATCHDOG_EN.
module motion_mode_scheduler #(
    parameter logic [15:0] STRAIGHT_T    = 16'd1024,
    parameter int unsigned BUMP_DEBOUNCE = 4,
    parameter logic [15:0] SPIN_TIMEOUT  = 16'd4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_bump,
    input  logic       i_cliff,
    input  logic       i_done_spin,
    motion_mode_scheduler_if.master mbus,
    output logic [2:0] o_mode,
    output logic [7:0] o_bump_count,
    output logic       o_fault
);

    localparam int unsigned DB_W = $clog2(BUMP_DEBOUNCE + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPIRAL = 3'd1,
        S_TURN   = 3'd2,
        S_CRUISE = 3'd3,
        S_REARM  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DB_W-1:0] r_db_cnt;
    logic [15:0]     r_timer;
    logic [7:0]      r_bump_count;
    logic            r_spiral_en;
    logic            r_turn_en;
    logic [2:0]      r_speed;
    logic [9:0]      r_cmd;

    logic            w_bump_event;
    logic            w_halt_req;
    logic            w_bump_accept;
    logic            w_wd_expire;
    logic            w_wd_trip;
    logic            w_fault;
    logic            w_spiral_en;
    logic            w_turn_en;
    logic [2:0]      w_speed;
    logic [9:0]      w_cmd;

    // Debounce: counter saturates one past the trigger point so a held bump fires once
    assign w_bump_event = i_bump && (r_db_cnt == DB_W'(BUMP_DEBOUNCE - 1));
    assign w_halt_req   = i_cliff | i_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
        end else if (!i_bump) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt != DB_W'(BUMP_DEBOUNCE)) begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

`ifdef MOTION_SPIN_WATCHDOG_EN
    logic [15:0] r_wd_cnt;
    logic        r_fault;

    assign w_wd_expire = (r_wd_cnt == (SPIN_TIMEOUT - 16'd1));
    assign w_fault     = r_fault;

    // Spin watchdog counts TURN cycles, restarting on every entry to TURN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_fault  <= 1'b0;
        end else begin
            if (w_next == S_TURN && r_state == S_TURN) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_wd_trip) begin
                r_fault <= 1'b1;
            end
        end
    end
`else
    logic w_unused_spin_timeout;

    assign w_unused_spin_timeout = ^SPIN_TIMEOUT;
    assign w_wd_expire           = 1'b0;
    assign w_fault               = 1'b0;
`endif

    // Next state and the output values that state will load
    always_comb begin
        w_next        = r_state;
        w_bump_accept = 1'b0;
        w_wd_trip     = 1'b0;
        w_spiral_en   = 1'b0;
        w_turn_en     = 1'b0;
        w_speed       = 3'd0;
        w_cmd         = 10'd0;

        case (r_state)
            S_IDLE: begin
                if (w_halt_req) begin
                    w_next = S_HALT;
                end else if (i_start) begin
                    w_next = S_SPIRAL;
                end
            end
            S_SPIRAL: begin
                if (w_halt_req) begin
                    w_next = S_HALT;
                end else if (w_bump_event) begin
                    w_next        = S_TURN;
                    w_bump_accept = 1'b1;
                end
            end
            S_TURN: begin
                if (w_halt_req) begin
                    w_next = S_HALT;
                end else if (i_done_spin) begin
                    w_next = S_CRUISE;
                end else if (w_wd_expire) begin
                    w_next    = S_HALT;
                    w_wd_trip = 1'b1;
                end
            end
            S_CRUISE: begin
                if (w_halt_req) begin
                    w_next = S_HALT;
                end else if (w_bump_event) begin
                    w_next        = S_REARM;
                    w_bump_accept = 1'b1;
                end else if (r_timer == (STRAIGHT_T - 16'd1)) begin
                    w_next = S_SPIRAL;
                end
            end
            S_REARM: begin
                w_next = w_halt_req ? S_HALT : S_TURN;
            end
            S_HALT: begin
                if (!w_halt_req && !w_fault) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        case (w_next)
            S_SPIRAL: begin
                w_spiral_en = 1'b1;
                w_speed     = mbus.spiral_speed;
                w_cmd       = mbus.spiral_command;
            end
            S_TURN, S_CRUISE: begin
                w_turn_en = 1'b1;
                w_speed   = mbus.turn_speed;
                w_cmd     = mbus.turn_command;
            end
            default: begin
                w_spiral_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_spiral_en  <= 1'b0;
            r_turn_en    <= 1'b0;
            r_speed      <= 3'd0;
            r_cmd        <= 10'd0;
            r_timer      <= 16'd0;
            r_bump_count <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_spiral_en <= w_spiral_en;
            r_turn_en   <= w_turn_en;
            r_speed     <= w_speed;
            r_cmd       <= w_cmd;
            if (w_next == S_CRUISE && r_state == S_CRUISE) begin
                r_timer <= r_timer + 16'd1;
            end else begin
                r_timer <= 16'd0;
            end
            if (w_bump_accept && r_bump_count != 8'hFF) begin
                r_bump_count <= r_bump_count + 8'd1;
            end
        end
    end

    assign mbus.spiral_enable  = r_spiral_en;
    assign mbus.turn_enable    = r_turn_en;
    assign mbus.output_speed   = r_speed;
    assign mbus.motion_command = r_cmd;
    assign o_mode              = r_state;
    assign o_bump_count        = r_bump_count;
    assign o_fault             = w_fault;

endmodule

// File: tb/tb_motion_mode_scheduler.sv
// Directed self-checking bench for motion_mode_scheduler.
module tb_motion_mode_scheduler;

    localparam logic [2:0] SP_SPD = 3'd5;
    localparam logic [9:0] SP_CMD = 10'h155;
    localparam logic [2:0] TU_SPD = 3'd2;
    localparam logic [9:0] TU_CMD = 10'h2AA;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, bump, cliff, done_spin;
    logic [2:0] mode;
    logic [7:0] bump_count;
    logic       fault;
    int         checks   = 0;
    int         failures = 0;

    motion_mode_scheduler_if mbus();

    motion_mode_scheduler #(
        .STRAIGHT_T   (16'd1024),
        .BUMP_DEBOUNCE(4),
        .SPIN_TIMEOUT (16'd16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_bump      (bump),
        .i_cliff     (cliff),
        .i_done_spin (done_spin),
        .mbus        (mbus),
        .o_mode      (mode),
        .o_bump_count(bump_count),
        .o_fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_mode, input logic e_sp,
                           input logic e_tu, input logic [2:0] e_spd, input logic [9:0] e_cmd);
        check({tag, "_mode"},   16'(mode),                 16'(e_mode));
        check({tag, "_sp_en"},  16'(mbus.spiral_enable),   16'(e_sp));
        check({tag, "_tu_en"},  16'(mbus.turn_enable),     16'(e_tu));
        check({tag, "_speed"},  16'(mbus.output_speed),    16'(e_spd));
        check({tag, "_cmd"},    16'(mbus.motion_command),  16'(e_cmd));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; bump = 1'b0; cliff = 1'b0; done_spin = 1'b0;
        mbus.spiral_speed = SP_SPD; mbus.spiral_command = SP_CMD;
        mbus.turn_speed   = TU_SPD; mbus.turn_command   = TU_CMD;
        repeat (3) tick();
        chk_out("reset", 3'd0, 1'b0, 1'b0, 3'd0, 10'd0);
        check("reset_bcnt",  16'(bump_count), 16'd0);
        check("reset_fault", 16'(fault),      16'd0);

        rst = 1'b0;
        tick();
        check("idle_hold", 16'(mode), 16'd0);
        start = 1'b1;
        tick();
        chk_out("start", 3'd1, 1'b1, 1'b0, SP_SPD, SP_CMD);
        start = 1'b0;

        // Three-sample bump is filtered out
        bump = 1'b1;
        repeat (3) tick();
        bump = 1'b0;
        tick();
        check("bump3_mode", 16'(mode), 16'd1);
        check("bump3_bcnt", 16'(bump_count), 16'd0);

        bump = 1'b1;
        repeat (3) tick();
        check("bump_pre_mode", 16'(mode), 16'd1);
        tick();
        chk_out("bump4", 3'd2, 1'b0, 1'b1, TU_SPD, TU_CMD);
        check("bump4_bcnt", 16'(bump_count), 16'd1);
        repeat (20) tick();
        check("bump_hold_mode", 16'(mode), 16'd2);
        check("bump_hold_bcnt", 16'(bump_count), 16'd1);
        bump = 1'b0;
        mbus.turn_command = 10'h0F0;
        tick();
        check("turn_mux_cmd", 16'(mbus.motion_command), 16'h0F0);
        mbus.turn_command = TU_CMD;

        done_spin = 1'b1;
        tick();
        chk_out("cruise_entry", 3'd3, 1'b0, 1'b1, TU_SPD, TU_CMD);
        done_spin = 1'b0;
        repeat (1023) tick();
        check("cruise_1023", 16'(mode), 16'd3);
        tick();
        chk_out("cruise_expire", 3'd1, 1'b1, 1'b0, SP_SPD, SP_CMD);

        // Bump accepted in CRUISE at timer=500 -> one REARM cycle -> TURN
        bump = 1'b1;
        repeat (4) tick();
        bump = 1'b0;
        check("turn2_mode", 16'(mode), 16'd2);
        check("turn2_bcnt", 16'(bump_count), 16'd2);
        done_spin = 1'b1;
        tick();
        done_spin = 1'b0;
        repeat (497) tick();
        bump = 1'b1;
        repeat (3) tick();
        check("cruise500_mode", 16'(mode), 16'd3);
        tick();
        chk_out("rearm", 3'd4, 1'b0, 1'b0, 3'd0, 10'd0);
        check("rearm_bcnt", 16'(bump_count), 16'd3);
        bump = 1'b0;
        tick();
        chk_out("rearm_turn", 3'd2, 1'b0, 1'b1, TU_SPD, TU_CMD);

        stop = 1'b1;
        tick();
        chk_out("stop_halt", 3'd5, 1'b0, 1'b0, 3'd0, 10'd0);
        stop = 1'b0;
        tick();
        check("halt_exit", 16'(mode), 16'd0);
        start = 1'b1; stop = 1'b1;
        tick();
        check("start_vs_stop", 16'(mode), 16'd5);
        stop = 1'b0;
        tick();
        check("halt_ignores_start", 16'(mode), 16'd0);
        tick();
        check("restart", 16'(mode), 16'd1);
        start = 1'b0;

        // cliff wins over a simultaneous bump_event
        bump = 1'b1;
        repeat (3) tick();
        cliff = 1'b1;
        tick();
        check("cliff_mode", 16'(mode), 16'd5);
        check("cliff_bcnt", 16'(bump_count), 16'd3);
        bump = 1'b0; cliff = 1'b0; stop = 1'b1;
        tick();
        check("halt_stop_hold", 16'(mode), 16'd5);
        stop = 1'b0;
        tick();
        check("halt_release", 16'(mode), 16'd0);

        // bump_count saturation through repeated CRUISE->REARM->TURN loops
        start = 1'b1;
        tick();
        start = 1'b0;
        bump = 1'b1;
        repeat (4) tick();
        bump = 1'b0;
        check("sat_start_bcnt", 16'(bump_count), 16'd4);
        for (int i = 0; i < 255; i++) begin
            done_spin = 1'b1;
            tick();
            done_spin = 1'b0;
            bump = 1'b1;
            repeat (4) tick();
            bump = 1'b0;
            tick();
            if (i == 249) check("sat_254", 16'(bump_count), 16'd254);
        end
        check("sat_255", 16'(bump_count), 16'd255);
        check("sat_mode", 16'(mode), 16'd2);

        // Asynchronous reset between edges while in CRUISE
        done_spin = 1'b1;
        tick();
        done_spin = 1'b0;
        repeat (10) tick();
        check("pre_async_mode", 16'(mode), 16'd3);
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 3'd0, 1'b0, 1'b0, 3'd0, 10'd0);
        check("async_rst_bcnt", 16'(bump_count), 16'd0);
        rst = 1'b0;
        tick();
        check("post_rst_idle", 16'(mode), 16'd0);
        start = 1'b1;
        tick();
        chk_out("post_rst_start", 3'd1, 1'b1, 1'b0, SP_SPD, SP_CMD);
        start = 1'b0;

`ifdef MOTION_SPIN_WATCHDOG_EN
        bump = 1'b1;
        repeat (4) tick();
        bump = 1'b0;
        check("wd_turn", 16'(mode), 16'd2);
        repeat (15) tick();
        check("wd_pre_mode", 16'(mode), 16'd2);
        check("wd_pre_fault", 16'(fault), 16'd0);
        tick();
        check("wd_trip_mode", 16'(mode), 16'd5);
        check("wd_trip_fault", 16'(fault), 16'd1);
        repeat (5) tick();
        check("wd_sticky_mode", 16'(mode), 16'd5);
        check("wd_sticky_fault", 16'(fault), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wd_rst_fault", 16'(fault), 16'd0);
        check("wd_rst_mode", 16'(mode), 16'd0);
`else
        bump = 1'b1;
        repeat (4) tick();
        bump = 1'b0;
        repeat (40) tick();
        check("nowd_turn_mode", 16'(mode), 16'd2);
        check("nowd_fault", 16'(fault), 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
